// File: rtl/qcs_dyn_pre_gen_trace_cap_if.sv
// Drain port of the NHTP trace capture FIFO (show-ahead valid/ready).
interface qcs_dyn_pre_gen_trace_cap_if #(
  parameter int ENTRY_W = 77
);
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/qcs_dyn_pre_gen_trace_cap.sv
// Multi-channel NHTP read-request trace tap: stage 0 registers the request
// bus and TX context, stage 1 qualifies the capture and pushes one
// timestamped entry into a show-ahead FIFO drained over rd_if.
module qcs_dyn_pre_gen_trace_cap #(
  parameter int ADDR_DW   = 10,
  parameter int BW_W      = 2,
  parameter int GAMMA_W   = 4,
  parameter int SUBBAND_W = 4,
  parameter int N_CH      = 4,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cap_en,
  input  logic                      cap_clr,
  input  logic [1:0]                cap_mode,
  input  logic [N_CH-1:0]           ch_mask,
  input  logic [N_CH-1:0]           nhtp_re,
  input  logic [N_CH*ADDR_DW-1:0]   nhtp_raddr,
  input  logic [BW_W-1:0]           txconfig_bw,
  input  logic [BW_W-1:0]           sys_bw_mode,
  input  logic [SUBBAND_W-1:0]      config_mu_subband_present,
  input  logic [GAMMA_W-1:0]        config_gamma_rotation,
  input  logic [3:0]                n_tx,
  input  logic                      nhtp_4ch,
  qcs_dyn_pre_gen_trace_cap_if.master rd_if,
  output logic [$clog2(DEPTH):0]    fill_lvl,
  output logic [15:0]               drop_cnt,
  output logic                      cap_done
);
  localparam int ENTRY_W = TS_W + N_CH + N_CH*ADDR_DW + 2*BW_W + SUBBAND_W + GAMMA_W + 5;
  localparam int AW      = $clog2(DEPTH);

  // stage 0 registers
  logic                         s0_en;
  logic [1:0]                   s0_mode;
  logic [N_CH-1:0]              s0_mask, s0_re;
  logic [N_CH-1:0][ADDR_DW-1:0] s0_addr;
  logic [BW_W-1:0]              s0_bw, s0_sbw;
  logic [SUBBAND_W-1:0]         s0_sub;
  logic [GAMMA_W-1:0]           s0_gam;
  logic [3:0]                   s0_ntx;
  logic                         s0_4ch;
  logic [TS_W-1:0]              s0_ts, ts;

  // per-channel address history
  logic [N_CH-1:0][ADDR_DW-1:0] hist;
  logic [N_CH-1:0]              hist_vld;

  // stage 1 / FIFO
  logic [N_CH-1:0]              eff, chg;
  logic [N_CH-1:0][ADDR_DW-1:0] addr_m;
  logic [ENTRY_W-1:0]           entry;
  logic [ENTRY_W-1:0]           mem [DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [AW:0]                  cnt, cnt_nxt;
  logic                         live, is_m1, is_m2, cap_q, full, pop, wr, drop, done_set;

  // Capture the raw request bus and context; a clear discards anything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n || cap_clr) begin
      s0_en <= 1'b0; s0_mode <= '0; s0_mask <= '0; s0_re <= '0; s0_addr <= '0;
      s0_bw <= '0; s0_sbw <= '0; s0_sub <= '0; s0_gam <= '0; s0_ntx <= '0;
      s0_4ch <= 1'b0; s0_ts <= '0;
    end else begin
      s0_en <= cap_en; s0_mode <= cap_mode; s0_mask <= ch_mask; s0_re <= nhtp_re;
      s0_addr <= nhtp_raddr; s0_bw <= txconfig_bw; s0_sbw <= sys_bw_mode;
      s0_sub <= config_mu_subband_present; s0_gam <= config_gamma_rotation;
      s0_ntx <= n_tx; s0_4ch <= nhtp_4ch; s0_ts <= ts;
    end
  end

  // Per-channel masking and address-change detection.
  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    assign addr_m[g] = eff[g] ? s0_addr[g] : '0;
    assign chg[g]    = eff[g] && (!hist_vld[g] || (hist[g] != s0_addr[g]));
  end

  assign eff   = s0_re & s0_mask;
  assign live  = reset_n && !cap_clr;
  assign is_m1 = (s0_mode == 2'd1);
  assign is_m2 = (s0_mode == 2'd2);
  assign cap_q = live && s0_en && !cap_done && (|eff) && (!is_m1 || (|chg));
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign pop   = live && (cnt != '0) && rd_if.rd_ready;
  assign wr    = cap_q && (!full || pop);
  // Single-shot never drops: a capture that meets a full FIFO just ends the shot.
  assign drop  = cap_q && full && !pop && !is_m2;
  assign cnt_nxt  = cnt + (AW+1)'(wr) - (AW+1)'(pop);
  assign done_set = is_m2 && cap_q && (cnt_nxt == (AW+1)'(DEPTH));
  assign entry = {s0_ts, eff, addr_m, s0_bw, s0_sbw, s0_sub, s0_gam, s0_ntx, s0_4ch};

  // History follows every qualified capture, including ones that get dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist     <= '0;
      hist_vld <= '0;
    end else if (cap_clr) begin
      hist_vld <= '0;
    end else if (cap_q) begin
      for (int i = 0; i < N_CH; i++) begin
        if (eff[i]) begin
          hist[i]     <= s0_addr[i];
          hist_vld[i] <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!live) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nxt;
    end
  end

  // FIFO storage; content is only observable through rd_ptr while cnt != 0.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= entry;
  end

  // Timestamp, drop accounting and single-shot completion.
  always_ff @(posedge clk) begin
    if (!live) begin
      ts       <= '0;
      drop_cnt <= '0;
      cap_done <= 1'b0;
    end else begin
      if (cap_en) ts <= ts + 1'b1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (done_set) cap_done <= 1'b1;
    end
  end

  assign rd_if.rd_valid = (cnt != '0);
  assign rd_if.rd_data  = (cnt != '0) ? mem[rd_ptr] : '0;
  assign fill_lvl       = cnt;
endmodule

// File: tb/tb_qcs_dyn_pre_gen_trace_cap.sv
// Randomised plus directed bench for the NHTP trace capture tap, checked
// against a queue-based reference model of the capture rules.
module tb_qcs_dyn_pre_gen_trace_cap;
  localparam int EW = 77;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0, cap_en = 1'b0, cap_clr = 1'b0, rd_ready = 1'b0;
  logic [1:0]       cap_mode = '0;
  logic [3:0]       ch_mask = '0, nhtp_re = '0, n_tx = '0;
  logic [3:0][9:0]  raddr = '0;
  logic [1:0]       bw = '0, sbw = '0;
  logic [3:0]       sub = '0, gam = '0;
  logic             n4 = 1'b0;
  logic [4:0]       fill_lvl;
  logic [15:0]      drop_cnt;
  logic             cap_done;

  int n_tests = 0, n_fail = 0;

  qcs_dyn_pre_gen_trace_cap_if #(.ENTRY_W(EW)) rd_if ();
  assign rd_if.rd_ready = rd_ready;

  qcs_dyn_pre_gen_trace_cap dut (
    .clk(clk), .reset_n(reset_n), .cap_en(cap_en), .cap_clr(cap_clr),
    .cap_mode(cap_mode), .ch_mask(ch_mask), .nhtp_re(nhtp_re), .nhtp_raddr(raddr),
    .txconfig_bw(bw), .sys_bw_mode(sbw), .config_mu_subband_present(sub),
    .config_gamma_rotation(gam), .n_tx(n_tx), .nhtp_4ch(n4),
    .rd_if(rd_if), .fill_lvl(fill_lvl), .drop_cnt(drop_cnt), .cap_done(cap_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic            en;
    logic [1:0]      mode;
    logic [3:0]      re, mask;
    logic [3:0][9:0] addr;
    logic [1:0]      bw, sbw;
    logic [3:0]      sub, gam, ntx;
    logic            n4;
    logic [15:0]     ts;
  } samp_t;

  logic [EW-1:0]   q[$];
  int              m_drop = 0;
  bit              m_done = 0;
  logic [15:0]     m_ts = '0;
  logic [3:0][9:0] m_hist = '0;
  bit   [3:0]      m_hvld = '0;
  bit              p_have = 0;
  samp_t           p;

  always @(posedge clk) begin
    if (!reset_n || cap_clr) begin
      q.delete(); m_drop = 0; m_done = 0; m_ts = '0; m_hvld = '0; p_have = 0;
      if (!reset_n) m_hist = '0;
    end else begin
      bit pop, qual, any;
      logic [3:0] eff;
      logic [3:0][9:0] am;
      pop = rd_ready && (q.size() > 0);
      if (p_have) begin
        eff  = p.re & p.mask;
        qual = p.en && !m_done && (eff != 0);
        if (qual && p.mode == 2'd1) begin
          any = 0;
          for (int i = 0; i < 4; i++)
            if (eff[i] && (!m_hvld[i] || m_hist[i] != p.addr[i])) any = 1;
          qual = any;
        end
        if (qual) begin
          for (int i = 0; i < 4; i++) begin
            am[i] = eff[i] ? p.addr[i] : 10'd0;
            if (eff[i]) begin m_hist[i] = p.addr[i]; m_hvld[i] = 1; end
          end
          if (q.size() == 16 && !pop) begin
            if (p.mode == 2'd2) m_done = 1;
            else if (m_drop < 65535) m_drop++;
          end else begin
            if (pop) begin void'(q.pop_front()); pop = 0; end
            q.push_back({p.ts, eff, am, p.bw, p.sbw, p.sub, p.gam, p.ntx, p.n4});
            if (p.mode == 2'd2 && q.size() == 16) m_done = 1;
          end
        end
      end
      if (pop) void'(q.pop_front());
      p = '{cap_en, cap_mode, nhtp_re, ch_mask, raddr, bw, sbw, sub, gam, n_tx, n4, m_ts};
      p_have = 1;
      if (cap_en) m_ts = m_ts + 16'd1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare every output with the model.
  task automatic tick();
    @(posedge clk);
    #2;
    chk("rd_valid", rd_if.rd_valid, q.size() > 0);
    chk("fill_lvl", fill_lvl, q.size());
    chk("drop_cnt", drop_cnt, m_drop);
    chk("cap_done", cap_done, m_done);
    chk("rd_data", rd_if.rd_data, (q.size() > 0) ? q[0] : '0);
  endtask

  task automatic rd1(input int ch, input logic [9:0] a);
    nhtp_re = '0;
    nhtp_re[ch] = 1'b1;
    raddr[ch] = a;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    cap_clr = 1'b1; nhtp_re = '0; tick(); cap_clr = 1'b0;
  endtask

  initial begin
    ticks(2);
    chk("rst_valid", rd_if.rd_valid, 1'b0);
    chk("rst_fill", fill_lvl, 0);
    reset_n = 1'b1; cap_en = 1'b1; ch_mask = 4'hF; bw = 2'd2; n_tx = 4'd4;

    // consecutive reads on ch0
    for (int k = 0; k < 3; k++) begin
      rd1(0, 10'h10 + 10'(k));
      tick();
      if (k == 0) chk("t1_lat_n", rd_if.rd_valid, 1'b0);
      if (k == 1) chk("t1_lat_n1", rd_if.rd_valid, 1'b1);
    end
    nhtp_re = '0; ticks(2);
    chk("t1_fill", fill_lvl, 3);
    chk("t1_head_addr", rd_if.rd_data[26:17], 10'h10);
    rd_ready = 1'b1; ticks(4); rd_ready = 1'b0;

    // channel masking
    ch_mask = 4'h5; nhtp_re = 4'hF;
    raddr = {10'h3AA, 10'h2BB, 10'h1CC, 10'h0DD};
    tick(); nhtp_re = '0; ticks(2);
    chk("t2_mask", rd_if.rd_data[60:57], 4'h5);
    chk("t2_ch1", rd_if.rd_data[36:27], 0);
    chk("t2_ch3", rd_if.rd_data[56:47], 0);
    chk("t2_ch2", rd_if.rd_data[46:37], 10'h2BB);
    rd_ready = 1'b1; ticks(2); rd_ready = 1'b0; ch_mask = 4'hF;

    // address-change filter
    clr(); cap_mode = 2'd1;
    rd1(2, 10'h40); tick(); rd1(2, 10'h40); tick();
    rd1(2, 10'h41); tick(); rd1(2, 10'h40); tick();
    nhtp_re = '0; ticks(2);
    chk("t3_fill", fill_lvl, 3);
    rd_ready = 1'b1; ticks(4); rd_ready = 1'b0;

    // overflow and drops
    clr(); cap_mode = 2'd0;
    for (int k = 0; k < 20; k++) begin rd1(0, 10'($urandom_range(0, 1023))); tick(); end
    nhtp_re = '0; ticks(2);
    chk("t4_fill", fill_lvl, 16);
    chk("t4_drop", drop_cnt, 4);
    rd1(1, 10'h77); tick(); nhtp_re = '0; rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("t4_fill_pw", fill_lvl, 16);
    chk("t4_drop_pw", drop_cnt, 4);
    rd_ready = 1'b1; ticks(17); rd_ready = 1'b0;

    // single shot
    clr(); cap_mode = 2'd2;
    for (int k = 0; k < 20; k++) begin rd1(3, 10'(k)); tick(); end
    nhtp_re = '0; ticks(2);
    chk("t5_fill", fill_lvl, 16);
    chk("t5_done", cap_done, 1'b1);
    chk("t5_drop", drop_cnt, 0);
    rd_ready = 1'b1; ticks(17); rd_ready = 1'b0;
    chk("t5_drained", fill_lvl, 0);
    chk("t5_done_hold", cap_done, 1'b1);
    clr();
    chk("t5_clr_done", cap_done, 1'b0);
    chk("t5_clr_fill", fill_lvl, 0);

    // reset mid-capture, clear against a write
    cap_mode = 2'd0;
    for (int k = 0; k < 7; k++) begin rd1(1, 10'(k + 5)); tick(); end
    nhtp_re = '0; ticks(2);
    chk("t6_fill7", fill_lvl, 7);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("t6_rst_fill", fill_lvl, 0);
    chk("t6_rst_valid", rd_if.rd_valid, 1'b0);
    chk("t6_rst_data", rd_if.rd_data, 0);
    rd1(0, 10'h55); tick(); cap_clr = 1'b1; nhtp_re = '0; tick(); cap_clr = 1'b0; ticks(2);
    chk("t6_clr_wr", fill_lvl, 0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      reset_n  = ($urandom_range(0, 149) != 0);
      cap_clr  = ($urandom_range(0, 59) == 0);
      cap_en   = ($urandom_range(0, 7) != 0);
      cap_mode = 2'($urandom_range(0, 3));
      ch_mask  = 4'($urandom);
      nhtp_re  = 4'($urandom);
      for (int i = 0; i < 4; i++) raddr[i] = 10'h40 + 10'($urandom_range(0, 2));
      rd_ready = ($urandom_range(0, 2) == 0);
      bw = 2'($urandom); sbw = 2'($urandom); sub = 4'($urandom);
      gam = 4'($urandom); n_tx = 4'($urandom); n4 = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
